pool2d_stream: RTL and testbench
================================

POOL2D_STREAM -- requirements
Module: pool2d_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 32: signed element width.
REQ-002 SHALL have parameter H_IN, default 32: input rows.
REQ-003 SHALL have parameter W_IN, default 32: input columns.
REQ-004 SHALL have parameter CH, default 28: channels.
REQ-005 SHALL have parameter POOL, default 2: window size and stride; power of two, 2..8.
REQ-006 SHALL have parameter MODE, default 0: 0 = max, 1 = average.
REQ-007 SHALL have one clock and an asynchronous active-low reset.
REQ-008 SHALL have port clk, input, 1: the single clock, rising edge.
REQ-009 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-010 SHALL have port clear, input, 1: synchronous frame abort.
REQ-011 SHALL have port in_valid, input, 1: input element valid.
REQ-012 SHALL have port in_ready, output, 1: input element accepted when high with in_valid.
REQ-013 SHALL have port in_data, input, DATA_W: signed element.
REQ-014 SHALL have port out_valid, output, 1: pooled element valid.
REQ-015 SHALL have port out_ready, input, 1: downstream accepts.
REQ-016 SHALL have port out_data, output, DATA_W: signed pooled element.
REQ-017 SHALL have port frame_done, output, 1: one-cycle pulse after the last pooled element of a frame is accepted.

Function
REQ-018 SHALL accept input in raster order (row, column, channel), channel fastest, one element per handshake.
REQ-019 SHALL track input position with counters c (0..CH-1), w (0..W_IN-1), h (0..H_IN-1), wrapping c->w->h->frame.
REQ-020 SHALL hold one partial result per (output column, channel): (W_IN/POOL)*CH entries.
REQ-021 SHALL initialise the entry with the element when h%POOL==0 and w%POOL==0; otherwise update it (max: larger signed value; avg: signed sum).
REQ-022 SHALL size the avg accumulator at DATA_W+2*log2(POOL) bits with no overflow.
REQ-023 SHALL produce avg output as sum arithmetic-shifted right by 2*log2(POOL), floor rounding, truncated to DATA_W.
REQ-024 SHALL emit the pooled result when the element at h%POOL==POOL-1, w%POOL==POOL-1 is accepted, with out_valid high the next cycle (latency 1).
REQ-025 SHALL accept and discard elements with w >= (W_IN/POOL)*POOL or h >= (H_IN/POOL)*POOL, with no output and no buffer change.
REQ-026 SHALL drive in_ready = !out_valid || out_ready.
REQ-027 SHALL hold out_valid and out_data stable until out_ready.
REQ-028 SHALL, on simultaneous output acceptance and input of a window-final element, load the new result with out_valid staying high.
REQ-029 SHALL implement two states: ACC (out_valid low) and EMIT (out_valid high).
REQ-030 SHALL go ACC->EMIT on acceptance of a window-final element.
REQ-031 SHALL go EMIT->ACC on out_ready with no new window-final element.
REQ-032 SHALL pulse frame_done one cycle after the final pooled element of the frame is accepted.
REQ-033 SHALL restart counters at the next frame without idle cycles.
REQ-034 SHALL, on clear, zero counters, drop any pending output (out_valid low), state ACC, no frame_done; clear has priority over all handshakes that cycle.

Reset
REQ-035 SHALL, while rst_n is low, force state ACC, counters 0, out_valid 0, out_data 0, frame_done 0.
REQ-036 SHALL leave buffer contents undefined at reset, since the first row of each window overwrites them.
REQ-037 SHALL start a fresh frame when reset is released mid-frame.

Structure
REQ-038 SHALL place MODE encodings (POOL_MAX, POOL_AVG) and a clog2 constant function in shared package pool_pkg.
REQ-039 SHALL implement the partial-result buffer as sub-module pool_acc_buf (1 read + 1 write port, combinational read, synchronous write).

Verification
REQ-040 SHALL cover: MODE=0, H=W=4, CH=1, inputs 0..15 in raster order, out_ready=1 -> outputs 5,7,13,15, then frame_done.
REQ-041 SHALL cover: MODE=1, same stimulus -> outputs 2,4,10,12; window {-1,-2,-3,-3} -> -3 (floor).
REQ-042 SHALL cover: MODE=0, CH=2, window all -2^(DATA_W-1) on ch0 and 7 on ch1 -> -2^(DATA_W-1) then 7.
REQ-043 SHALL cover: out_ready=0 for 5 cycles at the first output -> in_ready low, out_data stable, no data lost.
REQ-044 SHALL cover: H=W=5, POOL=2 -> 4 outputs per channel, row/column 4 discarded, frame_done after 25*CH inputs.
REQ-045 SHALL cover: clear asserted mid-frame, then a full frame -> only the second frame's 4 outputs plus one frame_done.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared encodings and helpers for the streaming 2D pooling block.
package pool_pkg;
  localparam int POOL_MAX = 0;
  localparam int POOL_AVG = 1;

  typedef enum logic {ST_ACC, ST_EMIT} pool_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/pool_acc_buf.sv
// Partial-result store: one combinational read port, one synchronous write port.
module pool_acc_buf #(
  parameter int AW = 4,
  parameter int W  = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  // No reset: the first row of every window overwrites its entry.
  logic [W-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/pool2d_stream.sv
// Streaming POOLxPOOL max/average pooling over raster (row, col, channel) input.
module pool2d_stream
  import pool_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int H_IN   = 32,
  parameter int W_IN   = 32,
  parameter int CH     = 28,
  parameter int POOL   = 2,
  parameter int MODE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              frame_done
);
  localparam int LP    = clog2(POOL);
  localparam int OUT_W = W_IN / POOL;
  localparam int OUT_H = H_IN / POOL;
  localparam int ACC_W = DATA_W + 2*LP;
  localparam int CW    = clog2(CH + 1);
  localparam int WW    = clog2(W_IN + 1);
  localparam int HW    = clog2(H_IN + 1);
  localparam int DEPTH = (OUT_W*CH > 1) ? OUT_W*CH : 2;
  localparam int AW    = clog2(DEPTH);

  pool_state_e state, state_n;

  logic [CW-1:0] c;
  logic [WW-1:0] w;
  logic [HW-1:0] h;
  logic          c_end, w_end, h_end;
  logic          accept, in_win, first, last, emit, frame_end;
  logic [AW-1:0] addr;

  logic signed [ACC_W-1:0] ext_in, rd, upd;
  logic [ACC_W-1:0]        rdata;
  logic [DATA_W-1:0]       res;
  logic                    out_last;

  assign out_valid = (state == ST_EMIT);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  assign c_end = (c == CW'(CH - 1));
  assign w_end = (w == WW'(W_IN - 1));
  assign h_end = (h == HW'(H_IN - 1));

  // Trailing rows/columns that do not fill a whole window are dropped.
  assign in_win    = (w < WW'(OUT_W*POOL)) && (h < HW'(OUT_H*POOL));
  assign first     = (w[LP-1:0] == '0) && (h[LP-1:0] == '0);
  assign last      = (w[LP-1:0] == '1) && (h[LP-1:0] == '1);
  assign emit      = accept && in_win && last;
  assign frame_end = (w == WW'(OUT_W*POOL - 1)) && (h == HW'(OUT_H*POOL - 1)) && c_end;

  assign addr = AW'(w >> LP) * AW'(CH) + AW'(c);

  assign ext_in = ACC_W'(signed'(in_data));
  assign rd     = rdata;

  always_comb begin
    upd = rd;
    if (first)                 upd = ext_in;
    else if (MODE == POOL_AVG) upd = rd + ext_in;
    else if (ext_in > rd)      upd = ext_in;
  end

  // Arithmetic shift gives floor rounding for negative sums.
  assign res = (MODE == POOL_AVG) ? DATA_W'(upd >>> (2*LP)) : DATA_W'(upd);

  pool_acc_buf #(.AW(AW), .W(ACC_W)) u_buf (
    .clk   (clk),
    .we    (accept && in_win && !clear),
    .waddr (addr),
    .wdata (upd),
    .raddr (addr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c <= '0;
      w <= '0;
      h <= '0;
    end else if (clear) begin
      c <= '0;
      w <= '0;
      h <= '0;
    end else if (accept) begin
      if (!c_end) c <= c + 1'b1;
      else begin
        c <= '0;
        if (!w_end) w <= w + 1'b1;
        else begin
          w <= '0;
          h <= h_end ? '0 : h + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ACC;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_ACC:  if (emit) state_n = ST_EMIT;
      ST_EMIT: if (out_ready && !emit) state_n = ST_ACC;
      default: state_n = ST_ACC;
    endcase
    if (clear) state_n = ST_ACC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= !clear && out_valid && out_ready && out_last;
      if (clear) begin
        out_data <= '0;
        out_last <= 1'b0;
      end else if (emit) begin
        out_data <= res;
        out_last <= frame_end;
      end
    end
  end
endmodule

// File: tb/tb_pool2d_stream.sv
// Self-checking bench: four pooling configurations driven one at a time, scoreboard on outputs.
module tb_pool2d_stream;
  localparam int DW = 16;

  typedef struct {
    int dut;
    int win[4];
    int exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0] iv, ir, ov, ordy, fd, clr;
  logic signed [DW-1:0] din;
  logic signed [DW-1:0] od [4];

  int checks = 0;
  int errors = 0;
  int cur = 0;
  int fd_cnt = 0;
  bit stall_arm = 1'b0;
  logic signed [DW-1:0] exp_q[$];
  logic signed [DW-1:0] mon_e;
  logic signed [DW-1:0] held;
  int fv[5][5][2];
  vec_t tbl[11];

  pool2d_stream #(.DATA_W(DW), .H_IN(4), .W_IN(4), .CH(1), .POOL(2), .MODE(0)) u_max (
    .clk(clk), .rst_n(rst_n), .clear(clr[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(din), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .frame_done(fd[0]));
  pool2d_stream #(.DATA_W(DW), .H_IN(4), .W_IN(4), .CH(1), .POOL(2), .MODE(1)) u_avg (
    .clk(clk), .rst_n(rst_n), .clear(clr[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(din), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .frame_done(fd[1]));
  pool2d_stream #(.DATA_W(DW), .H_IN(4), .W_IN(4), .CH(2), .POOL(2), .MODE(0)) u_ch2 (
    .clk(clk), .rst_n(rst_n), .clear(clr[2]), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(din), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .frame_done(fd[2]));
  pool2d_stream #(.DATA_W(DW), .H_IN(5), .W_IN(5), .CH(2), .POOL(2), .MODE(0)) u_odd (
    .clk(clk), .rst_n(rst_n), .clear(clr[3]), .in_valid(iv[3]), .in_ready(ir[3]),
    .in_data(din), .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(od[3]), .frame_done(fd[3]));

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard: an output transfers when valid and ready are both high at the coming edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fd[cur]) fd_cnt++;
      if (ov[cur] && ordy[cur] && !clr[cur]) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0d expected none", od[cur]);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_data", od[cur], mon_e);
        end
      end
    end
  end

  // One-shot backpressure: hold out_ready low for 5 cycles once an output appears.
  initial forever begin
    @(posedge clk); #2;
    if (stall_arm && ov[cur]) begin
      stall_arm = 1'b0;
      ordy[cur] = 1'b0;
      held = od[cur];
      repeat (5) begin
        @(negedge clk);
        chk("stall_in_ready", ir[cur], 0);
        chk("stall_out_data", od[cur], held);
        chk("stall_out_valid", ov[cur], 1);
        @(posedge clk); #2;
      end
      ordy[cur] = 1'b1;
    end
  end

  task automatic send(input int v);
    int g;
    g = 0;
    din = DW'(v);
    iv[cur] = 1'b1;
    do begin
      @(negedge clk);
      g++;
    end while (!ir[cur] && g < 200);
    if (!ir[cur]) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end
    @(posedge clk); #1;
    iv[cur] = 1'b0;
  endtask

  task automatic run_frame(input int hh, input int ww, input int cc, input int mode, input bit model);
    int mx, sm, x;
    for (int h = 0; h < hh; h++)
      for (int w = 0; w < ww; w++)
        for (int c = 0; c < cc; c++) begin
          if (model && h % 2 == 1 && w % 2 == 1 && h < (hh/2)*2 && w < (ww/2)*2) begin
            mx = fv[h][w][c];
            sm = 0;
            for (int i = 0; i < 2; i++)
              for (int j = 0; j < 2; j++) begin
                x = fv[h-i][w-j][c];
                sm += x;
                if (x > mx) mx = x;
              end
            exp_q.push_back(DW'(mode != 0 ? (sm >>> 2) : mx));
          end
          send(fv[h][w][c]);
        end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(posedge clk);
      g++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic fill_raster();
    for (int h = 0; h < 4; h++)
      for (int w = 0; w < 4; w++) fv[h][w][0] = h*4 + w;
  endtask

  task automatic push4(input int a, input int b, input int c, input int d);
    exp_q.push_back(DW'(a));
    exp_q.push_back(DW'(b));
    exp_q.push_back(DW'(c));
    exp_q.push_back(DW'(d));
  endtask

  task automatic set_vec(input int i, input int d, input int a, input int b,
                         input int c, input int e, input int x);
    tbl[i].dut = d;
    tbl[i].win[0] = a;
    tbl[i].win[1] = b;
    tbl[i].win[2] = c;
    tbl[i].win[3] = e;
    tbl[i].exp = x;
  endtask

  initial begin
    iv = '0; ordy = '1; clr = '0; din = '0;
    rst_n = 1'b0;

    set_vec(0, 0, 1, 2, 3, 4, 4);
    set_vec(1, 0, -5, -1, -7, -3, -1);
    set_vec(2, 0, 7, 0, 0, 0, 7);
    set_vec(3, 0, -32768, -32768, -32768, -32768, -32768);
    set_vec(4, 0, 32767, -32768, 0, 1, 32767);
    set_vec(5, 1, -1, -2, -3, -3, -3);
    set_vec(6, 1, 1, 2, 3, 4, 2);
    set_vec(7, 1, 32767, 32767, 32767, 32767, 32767);
    set_vec(8, 1, -32768, -32768, -32768, -32768, -32768);
    set_vec(9, 1, 1, 1, 1, 0, 0);
    set_vec(10, 1, -1, 0, 0, 0, -1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk("rst_out_valid", ov[d], 0);
      chk("rst_out_data", od[d], 0);
      chk("rst_frame_done", fd[d], 0);
      chk("rst_in_ready", ir[d], 1);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Max over a 0..15 raster frame.
    cur = 0; fd_cnt = 0;
    fill_raster();
    push4(5, 7, 13, 15);
    run_frame(4, 4, 1, 0, 1'b0);
    drain();
    chk("max_frame_done", fd_cnt, 1);

    // Average over the same frame.
    cur = 1; fd_cnt = 0;
    push4(2, 4, 10, 12);
    run_frame(4, 4, 1, 1, 1'b0);
    drain();
    chk("avg_frame_done", fd_cnt, 1);

    // Table: every window of a frame carries the same four values.
    for (int i = 0; i < 11; i++) begin
      cur = tbl[i].dut; fd_cnt = 0;
      for (int h = 0; h < 4; h++)
        for (int w = 0; w < 4; w++) fv[h][w][0] = tbl[i].win[(h%2)*2 + (w%2)];
      push4(tbl[i].exp, tbl[i].exp, tbl[i].exp, tbl[i].exp);
      run_frame(4, 4, 1, 0, 1'b0);
      drain();
      chk("tbl_frame_done", fd_cnt, 1);
    end

    // Two channels, most-negative value on ch0.
    cur = 2; fd_cnt = 0;
    for (int h = 0; h < 4; h++)
      for (int w = 0; w < 4; w++) begin
        fv[h][w][0] = -32768;
        fv[h][w][1] = 7;
      end
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(DW'(-32768));
      exp_q.push_back(DW'(7));
    end
    run_frame(4, 4, 2, 0, 1'b0);
    drain();
    chk("ch2_frame_done", fd_cnt, 1);

    // Backpressure on the first output.
    cur = 0; fd_cnt = 0;
    fill_raster();
    push4(5, 7, 13, 15);
    stall_arm = 1'b1;
    run_frame(4, 4, 1, 0, 1'b0);
    drain();
    chk("stall_taken", stall_arm, 0);
    chk("stall_frame_done", fd_cnt, 1);

    // 5x5 frame: last row/column discarded; two back-to-back frames.
    cur = 3; fd_cnt = 0;
    for (int h = 0; h < 5; h++)
      for (int w = 0; w < 5; w++)
        for (int c = 0; c < 2; c++) fv[h][w][c] = h*100 + w*10 + c - 200;
    run_frame(5, 5, 2, 0, 1'b1);
    fv[0][0][0] = 999;
    fv[3][3][1] = -999;
    run_frame(5, 5, 2, 0, 1'b1);
    drain();
    chk("odd_frame_done", fd_cnt, 2);

    // Clear with a pending output, then a full frame.
    cur = 0; fd_cnt = 0;
    ordy[0] = 1'b0;
    for (int k = 0; k < 6; k++) send(k);
    @(negedge clk);
    chk("clr_pending_valid", ov[0], 1);
    @(posedge clk); #1;
    clr[0] = 1'b1;
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    clr[0] = 1'b0;
    @(negedge clk);
    chk("clr_out_valid", ov[0], 0);
    chk("clr_frame_done", fd[0], 0);
    @(posedge clk); #1;
    fill_raster();
    push4(5, 7, 13, 15);
    run_frame(4, 4, 1, 0, 1'b0);
    drain();
    chk("clr_frame_done_cnt", fd_cnt, 1);

    // Reset released mid-frame starts a fresh frame.
    fd_cnt = 0;
    for (int k = 0; k < 3; k++) send(k);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    push4(5, 7, 13, 15);
    run_frame(4, 4, 1, 0, 1'b0);
    drain();
    chk("rst_mid_frame_done", fd_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
